// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, byte-enable constants and state encoding for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] WME_BYTE = 4'b0001;
    localparam logic [3:0] WME_HALF = 4'b0011;
    localparam logic [3:0] WME_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd1;
        endcase
    endfunction

    // The illegal size code maps to no enables so it can never write.
    function automatic logic [3:0] wme_for(input logic [1:0] size);
        case (size)
            SIZE_BYTE: wme_for = WME_BYTE;
            SIZE_HALF: wme_for = WME_HALF;
            SIZE_WORD: wme_for = WME_WORD;
            default:   wme_for = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory signals of the load/store unit
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic [3:0]  mem_wme;
    logic [7:0]  mem_do0;
    logic [7:0]  mem_do1;
    logic [7:0]  mem_do2;
    logic [7:0]  mem_do3;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_do0, mem_do1, mem_do2, mem_do3,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_datain, mem_wme
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_do0, mem_do1, mem_do2, mem_do3,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_datain, mem_wme
    );

endinterface

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of four little-endian load bytes by access size
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = {b3, b2, b1, b0};
        case (size)
            SIZE_BYTE: result = {{24{~is_unsigned & b0[7]}}, b0};
            SIZE_HALF: result = {{16{~is_unsigned & b1[7]}}, b1, b0};
            default:   result = {b3, b2, b1, b0};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-at-a-time load/store sequencer into the byte-addressed data memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] raw_q, raw_d;

    logic        req_err;
    logic [32:0] last_byte;

    // Last touched byte is computed in 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        last_byte = {1'b0, bus.req_addr} + 33'(size_bytes(bus.req_size)) - 33'd1;
        req_err   = (bus.req_size == 2'b11)
                  || ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
                  || ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
                  || (last_byte >= 33'(MEM_BYTES));
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        raw_d   = raw_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d  = bus.req_we;
                    size_d = bus.req_size;
                    uns_d = bus.req_unsigned;
                    err_d = req_err;
                    raw_d = 32'h0;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else begin
                        // The memory bus only moves for accesses that will really happen.
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    raw_d = {bus.mem_do3, bus.mem_do2, bus.mem_do1, bus.mem_do0};
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            raw_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            raw_q   <= raw_d;
        end
    end

    lsu_extend u_extend (
        .b0          (raw_q[7:0]),
        .b1          (raw_q[15:8]),
        .b2          (raw_q[23:16]),
        .b3          (raw_q[31:24]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (bus.resp_rdata)
    );

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_err    = err_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_datain  = wdata_q;
    assign bus.mem_wme     = ((state_q == ST_ACCESS) && we_q) ? wme_for(size_q) : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte memory and reference model
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wme[i]) mem[bus.mem_address[7:0] + 8'(i)] <= bus.mem_datain[8*i +: 8];
        end
    end

    assign bus.mem_do0 = mem[bus.mem_address[7:0]];
    assign bus.mem_do1 = mem[bus.mem_address[7:0] + 8'd1];
    assign bus.mem_do2 = mem[bus.mem_address[7:0] + 8'd2];
    assign bus.mem_do3 = mem[bus.mem_address[7:0] + 8'd3];

    logic [7:0] ref_mem [256];

    function automatic longint nbytes(input logic [1:0] size);
        return (size == 2'd2) ? 4 : (size == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        longint a = longint'(addr);
        longint n = nbytes(size);
        if (size == 2'd3) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        return (a + n - 1) >= 256;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        longint n = nbytes(size);
        longint v = 0;
        for (longint i = 0; i < n; i++) v += longint'(ref_mem[addr[7:0] + 8'(i)]) << (8 * i);
        if (!uns && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < int'(nbytes(size)); i++) ref_mem[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Caller is #1 after a rising edge with the unit idle.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int wme_cyc, output logic [3:0] wme_seen);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.resp_ready   = (stall == 0);
        wme_cyc  = 0;
        wme_seen = 4'b0000;
        check("req_ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            if (bus.mem_wme != 4'b0000) begin wme_cyc++; wme_seen = bus.mem_wme; end
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        for (int s = 0; s < stall; s++) begin
            if (bus.mem_wme != 4'b0000) wme_cyc++;
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [20];

    task automatic check_txn(input string name, input logic we, input logic [1:0] size,
                             input logic [31:0] rdata, input logic err, input int lat,
                             input int wme_cyc, input logic [3:0] wme_seen,
                             input logic exp_err, input logic [31:0] exp_rdata);
        logic        wr;
        logic [3:0]  exp_wme;
        wr      = we && !exp_err;
        exp_wme = wr ? 4'((1 << nbytes(size)) - 1) : 4'b0000;
        check({name, "_err"},   {31'b0, err}, {31'b0, exp_err});
        check({name, "_rdata"}, rdata, exp_rdata);
        check({name, "_lat"},   32'(lat), exp_err ? 32'd1 : 32'd2);
        check({name, "_wme_cycles"}, 32'(wme_cyc), wr ? 32'd1 : 32'd0);
        check({name, "_wme_value"},  {28'b0, wme_seen}, {28'b0, exp_wme});
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat, wme_cyc;
        logic [3:0]  wme_seen;
        logic        r_we, r_uns, e_err;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata, e_rdata;

        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h21,       32'h00000080, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h21,       32'h0,        1'b0, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h21,       32'h0,        1'b0, 32'h00000080};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h30,       32'h11223344, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h30,       32'h00008001, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h30,       32'h0,        1'b0, 32'hFFFF8001};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h30,       32'h0,        1'b0, 32'h11228001};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h12,       32'h55555555, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h05,       32'h0,        1'b1, 32'h0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'hFD,       32'h0,        1'b1, 32'h0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h40,       32'h0,        1'b1, 32'h0};
        vecs[13] = '{1'b1, 2'd3, 1'b0, 32'h40,       32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'hFC,       32'h0,        1'b0, 32'h0};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 32'hFF,       32'h000000A5, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 2'd0, 1'b1, 32'hFF,       32'h0,        1'b0, 32'h000000A5};
        vecs[17] = '{1'b0, 2'd1, 1'b0, 32'hFE,       32'h0,        1'b0, 32'hFFFFA500};
        vecs[18] = '{1'b0, 2'd1, 1'b1, 32'hFE,       32'h0,        1'b0, 32'h0000A500};
        vecs[19] = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
        check("rst_mem_address", bus.mem_address, 32'h0);
        check("rst_mem_datain",  bus.mem_datain,  32'h0);
        check("rst_mem_wme",    {28'b0, bus.mem_wme},    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 20; v++) begin
            run_req(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata, 0,
                    rdata, err, lat, wme_cyc, wme_seen);
            check_txn($sformatf("vec%0d", v), vecs[v].we, vecs[v].size, rdata, err, lat,
                      wme_cyc, wme_seen, vecs[v].exp_err, vecs[v].exp_rdata);
            if (vecs[v].we && !vecs[v].exp_err) model_store(vecs[v].size, vecs[v].addr, vecs[v].wdata);
        end

        // Response held with resp_ready low must stay frozen.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        check("hold_access_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            check("hold_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
            check("hold_req_ready",  {31'b0, bus.req_ready},  32'd0);
            check("hold_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
            check("hold_resp_err",   {31'b0, bus.resp_err},   32'd0);
            check("hold_mem_wme",    {28'b0, bus.mem_wme},    32'd0);
            @(posedge clk); #1;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("release_resp_valid", {31'b0, bus.resp_valid}, 32'd0);

        // Reset in the middle of a word store aborts it.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 32'h50; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_wme_in_access", {28'b0, bus.mem_wme}, 32'hF);
        rst = 1'b1;
        #1;
        check("abort_wme",         {28'b0, bus.mem_wme},    32'd0);
        check("abort_req_ready",   {31'b0, bus.req_ready},  32'd1);
        check("abort_resp_valid",  {31'b0, bus.resp_valid}, 32'd0);
        check("abort_mem_address", bus.mem_address, 32'h0);
        check("abort_mem_datain",  bus.mem_datain,  32'h0);
        check("abort_resp_rdata",  bus.resp_rdata,  32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int c = 0; c < 3; c++) begin
            check("abort_no_resp", {31'b0, bus.resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rdata, err, lat, wme_cyc, wme_seen);
        check_txn("post_reset_load", 1'b0, 2'd2, rdata, err, lat, wme_cyc, wme_seen, 1'b0, 32'h0);
        run_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 0, rdata, err, lat, wme_cyc, wme_seen);
        check_txn("aborted_store_absent", 1'b0, 2'd2, rdata, err, lat, wme_cyc, wme_seen, 1'b0, 32'h0);

        for (int t = 0; t < 60; t++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_uns   = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            case ($urandom_range(0, 9))
                8:       r_addr = $urandom;
                9:       r_addr = 32'($urandom_range(248, 260));
                default: r_addr = 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) != 0 && r_size != 2'd0) r_addr[1:0] = 2'b00;
            e_err   = model_err(r_size, r_addr);
            e_rdata = (r_we || e_err) ? 32'h0 : model_load(r_size, r_uns, r_addr);
            run_req(r_we, r_size, r_uns, r_addr, r_wdata, int'($urandom_range(0, 2)),
                    rdata, err, lat, wme_cyc, wme_seen);
            check_txn($sformatf("rand%0d", t), r_we, r_size, rdata, err, lat, wme_cyc, wme_seen,
                      e_err, e_rdata);
            if (r_we && !e_err) model_store(r_size, r_addr, r_wdata);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
